// File: rtl/dc_bsp_pkg.sv
// dc_bsp_pkg: shared widths, arbiter state and read-tag layout for the kernel memory path
package dc_bsp_pkg;
  localparam int OPENCL_QSYS_ADDR_WIDTH = 32;
  localparam int OPENCL_BSP_KERNEL_DATA_WIDTH = 32;
  localparam int OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH = 5;
  localparam int OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH = 4;
  localparam int ID_W = 2;
  typedef enum logic {IDLE, WR_BURST} arb_state_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH-1:0] beats;
  } tag_t;
endpackage

// File: rtl/kernel_mem_arb_tag_fifo.sv
// kernel_mem_arb_tag_fifo: show-ahead tag FIFO; a pop frees room for a same-cycle push when full
module kernel_mem_arb_tag_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  // pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/kernel_mem_arb.sv
// kernel_mem_arb: round-robin arbiter sharing one burst memory port among kernel requesters
module kernel_mem_arb
  import dc_bsp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RSP_DEPTH = 16,
  parameter int WACK_DEPTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [NUM_REQ-1:0] r_read,
  input  logic [NUM_REQ-1:0] r_write,
  input  logic [NUM_REQ-1:0][OPENCL_QSYS_ADDR_WIDTH-1:0] r_address,
  input  logic [NUM_REQ-1:0][OPENCL_BSP_KERNEL_DATA_WIDTH-1:0] r_writedata,
  input  logic [NUM_REQ-1:0][OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH-1:0] r_burstcount,
  input  logic [NUM_REQ-1:0][OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH-1:0] r_byteenable,
  output logic [NUM_REQ-1:0] r_waitrequest,
  output logic [OPENCL_BSP_KERNEL_DATA_WIDTH-1:0] r_readdata,
  output logic [NUM_REQ-1:0] r_readdatavalid,
  output logic [NUM_REQ-1:0] r_writeack,
  output logic m_read,
  output logic m_write,
  output logic [OPENCL_QSYS_ADDR_WIDTH-1:0] m_address,
  output logic [OPENCL_BSP_KERNEL_DATA_WIDTH-1:0] m_writedata,
  output logic [OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH-1:0] m_burstcount,
  output logic [OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH-1:0] m_byteenable,
  input  logic m_waitrequest,
  input  logic [OPENCL_BSP_KERNEL_DATA_WIDTH-1:0] m_readdata,
  input  logic m_readdatavalid,
  input  logic m_writeack,
  output logic err_rsp_underflow
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH;
  arb_state_t state, state_d;
  logic [IW-1:0] last_grant, lock_id, sel, cand, wa_head;
  logic [BW-1:0] beats_left, rd_cnt, eff_bc;
  logic found, last_beat, blocked, go, rd_acc, wr_acc;
  logic rd_push, rd_pop, rd_full, rd_empty, wa_push, wa_pop, wa_full, wa_empty;
  tag_t rd_din, rd_head;
  assign rd_pop = m_readdatavalid && !rd_empty && rd_cnt == rd_head.beats - 1'b1;
  assign wa_pop = m_writeack && !wa_empty;
  assign rd_din = '{id: ID_W'(sel), beats: eff_bc};
  assign r_readdata = m_readdata;
  kernel_mem_arb_tag_fifo #(.W($bits(tag_t)), .DEPTH(RSP_DEPTH)) u_rd_fifo (
    .clk(clk), .reset_n(reset_n), .push(rd_push), .din(rd_din), .pop(rd_pop),
    .dout(rd_head), .full(rd_full), .empty(rd_empty)
  );
  kernel_mem_arb_tag_fifo #(.W(IW), .DEPTH(WACK_DEPTH)) u_wa_fifo (
    .clk(clk), .reset_n(reset_n), .push(wa_push), .din(sel), .pop(wa_pop),
    .dout(wa_head), .full(wa_full), .empty(wa_empty)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  end
  // grant selection, command forwarding, response routing and next state
  always_comb begin
    found = 1'b0;
    sel = lock_id;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (state == IDLE && !found && (r_read[cand] || r_write[cand])) begin
        found = 1'b1;
        sel = cand;
      end
    end
    eff_bc = r_burstcount[sel] == '0 ? BW'(1) : r_burstcount[sel];
    last_beat = state == WR_BURST && beats_left == BW'(1);
    blocked = state == WR_BURST ? last_beat && wa_full && !wa_pop
            : r_read[sel] ? rd_full && !rd_pop
            : eff_bc == BW'(1) && wa_full && !wa_pop;
    go = reset_n && (state == WR_BURST || found) && !blocked;
    m_read = go && state == IDLE && r_read[sel];
    m_write = go && r_write[sel] && (state == WR_BURST || !r_read[sel]);
    m_address = r_address[sel];
    m_writedata = r_writedata[sel];
    m_burstcount = r_burstcount[sel];
    m_byteenable = r_byteenable[sel];
    r_waitrequest = '1;
    if (go) r_waitrequest[sel] = m_waitrequest;
    rd_acc = m_read && !m_waitrequest;
    wr_acc = m_write && !m_waitrequest;
    rd_push = rd_acc;
    wa_push = wr_acc && (state == IDLE ? eff_bc == BW'(1) : last_beat);
    state_d = state;
    if (state == IDLE && wr_acc && eff_bc != BW'(1)) state_d = WR_BURST;
    else if (last_beat && wr_acc) state_d = IDLE;
    r_readdatavalid = '0;
    r_writeack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_readdatavalid[i] = m_readdatavalid && !rd_empty && rd_head.id == ID_W'(i);
      r_writeack[i] = wa_pop && wa_head == IW'(i);
    end
  end
  // grant history, burst lock, read beat counter and sticky underflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IW'(NUM_REQ - 1);
      lock_id <= '0;
      beats_left <= '0;
      rd_cnt <= '0;
      err_rsp_underflow <= 1'b0;
    end else begin
      if ((state == IDLE && rd_acc) || wa_push) last_grant <= sel;
      if (state == IDLE && wr_acc && eff_bc != BW'(1)) begin
        lock_id <= sel;
        beats_left <= eff_bc - 1'b1;
      end else if (state == WR_BURST && wr_acc) beats_left <= beats_left - 1'b1;
      if (m_readdatavalid && !rd_empty) rd_cnt <= rd_pop ? '0 : rd_cnt + 1'b1;
      if ((m_readdatavalid && rd_empty) || (m_writeack && wa_empty)) err_rsp_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kernel_mem_arb.sv
// tb_kernel_mem_arb: directed scoreboard bench for the kernel memory arbiter
module tb_kernel_mem_arb;
  import dc_bsp_pkg::*;
  localparam int NR = 2;
  localparam int AW = OPENCL_QSYS_ADDR_WIDTH;
  localparam int DW = OPENCL_BSP_KERNEL_DATA_WIDTH;
  localparam int BW = OPENCL_BSP_KERNEL_BURSTCOUNT_WIDTH;
  localparam int BEW = OPENCL_BSP_KERNEL_BYTEENABLE_WIDTH;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NR-1:0] r_read = '0, r_write = '0;
  logic [NR-1:0][AW-1:0] r_address = '0;
  logic [NR-1:0][DW-1:0] r_writedata = '0;
  logic [NR-1:0][BW-1:0] r_burstcount = '0;
  logic [NR-1:0][BEW-1:0] r_byteenable = '0;
  logic [NR-1:0] r_waitrequest, r_readdatavalid, r_writeack;
  logic [DW-1:0] r_readdata;
  logic m_read, m_write, err_rsp_underflow;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_writedata;
  logic [BW-1:0] m_burstcount;
  logic [BEW-1:0] m_byteenable;
  logic m_waitrequest = 1'b0, m_readdatavalid = 1'b0, m_writeack = 1'b0;
  logic [DW-1:0] m_readdata = '0;
  typedef struct {bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [BW-1:0] bc;} cmd_t;
  typedef struct {logic [NR-1:0] vec; logic [DW-1:0] data;} rsp_t;
  cmd_t rq[NR][$];
  cmd_t exp_cmd[$];
  rsp_t exp_rd[$];
  logic [NR-1:0] exp_wa[$];
  int acc_cyc[$];
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  logic [NR-1:0] drv_acc;
  cmd_t mon_c;
  rsp_t mon_r;
  logic [NR-1:0] mon_w;

  always #5 clk = ~clk;

  kernel_mem_arb #(.NUM_REQ(NR), .RSP_DEPTH(16), .WACK_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .r_read(r_read), .r_write(r_write), .r_address(r_address), .r_writedata(r_writedata),
    .r_burstcount(r_burstcount), .r_byteenable(r_byteenable), .r_waitrequest(r_waitrequest),
    .r_readdata(r_readdata), .r_readdatavalid(r_readdatavalid), .r_writeack(r_writeack),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_burstcount(m_burstcount), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_writeack(m_writeack),
    .err_rsp_underflow(err_rsp_underflow)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic cmd_t mk(bit wr, int a, int d, int bc);
    cmd_t c;
    c.wr = wr;
    c.addr = AW'(a);
    c.data = DW'(d);
    c.bc = BW'(bc);
    return c;
  endfunction

  // requesters: hold the head command until it is seen accepted, then advance
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NR; g++) drv_acc[g] = reset_n && (r_read[g] || r_write[g]) && !r_waitrequest[g];
    @(posedge clk);
    #1;
    for (int g = 0; g < NR; g++) begin
      if (drv_acc[g] && rq[g].size() > 0) void'(rq[g].pop_front());
      if (rq[g].size() > 0) begin
        r_read[g] = !rq[g][0].wr;
        r_write[g] = rq[g][0].wr;
        r_address[g] = rq[g][0].addr;
        r_writedata[g] = rq[g][0].data;
        r_burstcount[g] = rq[g][0].bc;
        r_byteenable[g] = '1;
      end else begin
        r_read[g] = 1'b0;
        r_write[g] = 1'b0;
      end
    end
  end

  // monitor: compare memory-side commands and routed responses against the queues
  initial forever begin
    @(negedge clk);
    cyc++;
    if ((m_read || m_write) && !m_waitrequest) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'(m_address), 64'hFFFF_FFFF);
      else begin
        mon_c = exp_cmd.pop_front();
        chk("cmd_wr", 64'(m_write), 64'(mon_c.wr));
        chk("cmd_addr", 64'(m_address), 64'(mon_c.addr));
        chk("cmd_bc", 64'(m_burstcount), 64'(mon_c.bc));
        if (mon_c.wr) chk("cmd_data", 64'(m_writedata), 64'(mon_c.data));
      end
    end
    if (m_readdatavalid) begin
      if (exp_rd.size() == 0) chk("rdv_unexpected", 64'(r_readdatavalid), 64'hFF);
      else begin
        mon_r = exp_rd.pop_front();
        chk("rdv_vec", 64'(r_readdatavalid), 64'(mon_r.vec));
        if (mon_r.vec != '0) chk("rd_data", 64'(r_readdata), 64'(mon_r.data));
      end
    end else chk("rdv_idle", 64'(r_readdatavalid), 64'd0);
    if (m_writeack) begin
      if (exp_wa.size() == 0) chk("wack_unexpected", 64'(r_writeack), 64'hFF);
      else begin
        mon_w = exp_wa.pop_front();
        chk("wack_vec", 64'(r_writeack), 64'(mon_w));
      end
    end else chk("wack_idle", 64'(r_writeack), 64'd0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd_beat(input logic [DW-1:0] d, input logic [NR-1:0] v);
    exp_rd.push_back('{v, d});
    m_readdatavalid = 1'b1;
    m_readdata = d;
    step();
    m_readdatavalid = 1'b0;
  endtask

  task automatic wack(input logic [NR-1:0] v);
    exp_wa.push_back(v);
    m_writeack = 1'b1;
    step();
    m_writeack = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0 || exp_cmd.size() > 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk({name, "_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic wait_acc(input string name, input int from);
    int n = 0;
    while (acc_cnt == from && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({name, "_timeout"}, 64'(n), 64'd0);
  endtask

  initial begin
    int n0;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) step();
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_m_write", 64'(m_write), 64'd0);
    chk("rst_waitreq", 64'(r_waitrequest), 64'h3);
    chk("rst_err", 64'(err_rsp_underflow), 64'd0);
    chk("rst_last_grant", 64'(dut.last_grant), 64'd1);
    reset_n = 1'b1;
    step();
    // two simultaneous 4-beat reads: req0 first, req1 on the next cycle
    rq[0].push_back(mk(0, 'h000, 0, 4));
    rq[1].push_back(mk(0, 'h100, 0, 4));
    exp_cmd.push_back(mk(0, 'h000, 0, 4));
    exp_cmd.push_back(mk(0, 'h100, 0, 4));
    n0 = acc_cyc.size();
    drain("A", 30);
    chk("A_back_to_back", 64'(acc_cyc.size() >= n0 + 2 ? acc_cyc[n0+1] - acc_cyc[n0] : 0), 64'd1);
    for (int k = 0; k < 8; k++) rd_beat(DW'('hA0 + k), k < 4 ? 2'b01 : 2'b10);
    // req1 3-beat write burst locks out req0's stream of reads
    for (int k = 0; k < 4; k++) rq[0].push_back(mk(0, 'h010 + k, 0, 1));
    rq[1].push_back(mk(1, 'h200, 'h11, 3));
    rq[1].push_back(mk(1, 'h200, 'h22, 3));
    rq[1].push_back(mk(1, 'h200, 'h33, 3));
    exp_cmd.push_back(mk(0, 'h010, 0, 1));
    exp_cmd.push_back(mk(1, 'h200, 'h11, 3));
    exp_cmd.push_back(mk(1, 'h200, 'h22, 3));
    exp_cmd.push_back(mk(1, 'h200, 'h33, 3));
    for (int k = 1; k < 4; k++) exp_cmd.push_back(mk(0, 'h010 + k, 0, 1));
    drain("B", 40);
    for (int k = 0; k < 4; k++) rd_beat(DW'('hB0 + k), 2'b01);
    wack(2'b10);
    chk("B_err", 64'(err_rsp_underflow), 64'd0);
    // 4-beat write stalled for 5 cycles on beat 2
    for (int k = 1; k <= 4; k++) begin
      rq[0].push_back(mk(1, 'h300, k, 4));
      exp_cmd.push_back(mk(1, 'h300, k, 4));
    end
    wait_acc("C", acc_cnt);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("C_m_write_held", 64'(m_write), 64'd1);
      chk("C_beat2_data", 64'(m_writedata), 64'd2);
      chk("C_beats_left", 64'(dut.beats_left), 64'd3);
      chk("C_locked_state", 64'(dut.state), 64'(WR_BURST));
      step();
    end
    m_waitrequest = 1'b0;
    drain("C", 30);
    wack(2'b01);
    // read-tag FIFO full: 17th read waits until a burst completes
    for (int k = 0; k < 16; k++) begin
      rq[0].push_back(mk(0, 'h400 + k, 0, 2));
      exp_cmd.push_back(mk(0, 'h400 + k, 0, 2));
    end
    drain("D", 60);
    rq[0].push_back(mk(0, 'h410, 0, 2));
    exp_cmd.push_back(mk(0, 'h410, 0, 2));
    repeat (3) step();
    chk("D_full_waitreq", 64'(r_waitrequest[0]), 64'd1);
    chk("D_full_m_read", 64'(m_read), 64'd0);
    exp_rd.push_back('{2'b01, DW'('hD0)});
    m_readdatavalid = 1'b1;
    m_readdata = DW'('hD0);
    chk("D_mid_burst_waitreq", 64'(r_waitrequest[0]), 64'd1);
    step();
    exp_rd.push_back('{2'b01, DW'('hD1)});
    m_readdata = DW'('hD1);
    chk("D_pop_frees_waitreq", 64'(r_waitrequest[0]), 64'd0);
    chk("D_pop_frees_m_read", 64'(m_read), 64'd1);
    step();
    m_readdatavalid = 1'b0;
    drain("D2", 10);
    for (int k = 0; k < 32; k++) rd_beat(DW'('hD2 + k), 2'b01);
    // reset during write burst beat 2 of 4 discards everything
    for (int k = 5; k <= 8; k++) rq[0].push_back(mk(1, 'h500, k, 4));
    exp_cmd.push_back(mk(1, 'h500, 5, 4));
    wait_acc("E", acc_cnt);
    m_waitrequest = 1'b1;
    step();
    reset_n = 1'b0;
    rq[0].delete();
    step();
    chk("E_rst_m_write", 64'(m_write), 64'd0);
    chk("E_rst_waitreq", 64'(r_waitrequest), 64'h3);
    chk("E_rst_state", 64'(dut.state), 64'(IDLE));
    chk("E_rst_beats_left", 64'(dut.beats_left), 64'd0);
    step();
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    repeat (2) step();
    chk("E_idle_m_write", 64'(m_write), 64'd0);
    chk("E_err_before", 64'(err_rsp_underflow), 64'd0);
    rd_beat(DW'('hEE), 2'b00);
    chk("E_err_after", 64'(err_rsp_underflow), 64'd1);
    step();
    chk("end_exp_cmd", 64'(exp_cmd.size()), 64'd0);
    chk("end_exp_rd", 64'(exp_rd.size()), 64'd0);
    chk("end_exp_wa", 64'(exp_wa.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
